// File: rtl/ahb_sevenseg_ctrl.sv
// ahb_sevenseg_ctrl: AHB-Lite slave driving an 8-digit multiplexed seven-segment display (option: SEVENSEG_LEADING_ZERO_BLANK_EN)
module ahb_sevenseg_ctrl #(
  parameter int CLK_DIV = 1000
) (
  input  logic        SI_ClkIn,
  input  logic        SI_Reset_N,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic [7:0]  IO_7SEGEN_N,
  output logic [6:0]  IO_7SEG_N
);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic        valid_q, valid_d, write_q, write_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  digen_q, digen_d;
  logic [15:0] pre_q, pre_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  segen_q, segen_d;
  logic [6:0]  seg_q, seg_d;
  logic        sel, wr, tc, lz;
  logic [3:0]  nib;
  logic [31:0] rd;
  logic        unused_ok;
  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};
  assign IO_7SEGEN_N = segen_q;
  assign IO_7SEG_N = seg_q;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  assign lz = (idx_q != 3'd0) && ((data_q >> {idx_q, 2'b00}) == 32'd0);
`else
  assign lz = 1'b0;
`endif
  // Bus pipeline, register writes, scan counters and next display value
  always_comb begin
    sel = HSEL & HTRANS[1];
    valid_d = sel;
    write_d = sel ? HWRITE : write_q;
    off_d = sel ? HADDR[3:2] : off_q;
    wr = valid_q & write_q;
    data_d = (wr && off_q == 2'd0) ? HWDATA : data_q;
    digen_d = (wr && off_q == 2'd1) ? HWDATA[7:0] : digen_q;
    tc = pre_q == 16'(CLK_DIV - 1);
    pre_d = tc ? 16'd0 : pre_q + 16'd1;
    idx_d = tc ? idx_q + 3'd1 : idx_q;
    nib = data_q[{idx_q, 2'b00} +: 4];
    segen_d = ~(digen_q & (8'd1 << idx_q));
    seg_d = (~digen_q[idx_q] | lz) ? 7'h7F : SEG_LUT[nib];
    rd = off_q == 2'd0 ? data_q : off_q == 2'd1 ? {24'd0, digen_q} : 32'd0;
    HRDATA = (valid_q & ~write_q) ? rd : 32'd0;
  end
  // State registers, cleared asynchronously so a pending data phase is dropped
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      off_q <= 2'd0;
      data_q <= 32'd0;
      digen_q <= 8'hFF;
      pre_q <= 16'd0;
      idx_q <= 3'd0;
      segen_q <= 8'hFF;
      seg_q <= 7'h7F;
    end else begin
      valid_q <= valid_d;
      write_q <= write_d;
      off_q <= off_d;
      data_q <= data_d;
      digen_q <= digen_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      segen_q <= segen_d;
      seg_q <= seg_d;
    end
  end
endmodule

// File: tb/tb_ahb_sevenseg_ctrl.sv
// tb_ahb_sevenseg_ctrl: self-checking bench for ahb_sevenseg_ctrl against a cycle-count display model
module tb_ahb_sevenseg_ctrl;
  localparam int DIV = 4;
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic        SI_ClkIn = 1'b0;
  logic        SI_Reset_N = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = 2'd0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = 32'd0;
  logic [31:0] HRDATA;
  logic [7:0]  IO_7SEGEN_N;
  logic [6:0]  IO_7SEG_N;
  int checks = 0;
  int failures = 0;
  int n = 0;
  logic [31:0] mdata = 32'd0;
  logic [7:0]  mdigen = 8'hFF;

  ahb_sevenseg_ctrl #(.CLK_DIV(DIV)) dut (
    .SI_ClkIn(SI_ClkIn), .SI_Reset_N(SI_Reset_N), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .IO_7SEGEN_N(IO_7SEGEN_N), .IO_7SEG_N(IO_7SEG_N)
  );

  always #5 SI_ClkIn = ~SI_ClkIn;

  // number of clock edges seen since reset release
  always @(posedge SI_ClkIn or negedge SI_Reset_N)
    if (!SI_Reset_N) n <= 0;
    else n <= n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // display after cnt edges: digit slot (cnt-1)/DIV, showing data as it was before that edge
  function automatic logic [14:0] exp_disp(input int cnt, input logic [31:0] d, input logic [7:0] en);
    int i;
    logic [3:0] nib;
    logic [6:0] s;
    if (cnt == 0) return {8'hFF, 7'h7F};
    i = ((cnt - 1) / DIV) % 8;
    nib = 4'(d >> (4 * i));
    s = SEG[nib];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    if (i > 0 && (d >> (4 * i)) == 32'd0) s = 7'h7F;
`endif
    if (!en[i]) s = 7'h7F;
    return {~(en & 8'(1 << i)), s};
  endfunction

  function automatic logic [31:0] mread(input logic [1:0] off);
    return off == 2'd0 ? mdata : off == 2'd1 ? {24'd0, mdigen} : 32'd0;
  endfunction

  function automatic logic [31:0] addr(input logic [1:0] off);
    logic [31:0] r;
    r = $urandom;
    return {r[31:4], off, r[1:0]};
  endfunction

  task automatic disp_chk(input string tag);
    logic [14:0] e;
    e = exp_disp(n, mdata, mdigen);
    chk({tag, "_en"}, {24'd0, IO_7SEGEN_N}, {24'd0, e[14:7]});
    chk({tag, "_seg"}, {25'd0, IO_7SEG_N}, {25'd0, e[6:0]});
  endtask

  task automatic tick(input string tag);
    @(posedge SI_ClkIn);
    @(negedge SI_ClkIn);
    disp_chk(tag);
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d, input bit rd_after, input logic [1:0] roff);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr(off);
    tick("wr_addr");
    HWDATA = d;
    if (rd_after) begin
      HWRITE = 1'b0; HADDR = addr(roff);
    end else begin
      HSEL = 1'b0; HTRANS = 2'b00;
    end
    tick("wr_data");
    if (off == 2'd0) mdata = d;
    if (off == 2'd1) mdigen = d[7:0];
    if (rd_after) chk("rd_after_wr", HRDATA, mread(roff));
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = $urandom;
  endtask

  task automatic rd(input logic [1:0] off);
    HSEL = 1'b1; HTRANS = $urandom_range(0, 1) ? 2'b10 : 2'b11; HWRITE = 1'b0; HADDR = addr(off);
    tick("rd_addr");
    HSEL = 1'b0; HTRANS = 2'b00;
    chk("rd_data", HRDATA, mread(off));
  endtask

  initial begin
    logic [31:0] d;
    int k;
    repeat (10) tick("reset");
    chk("reset_hrdata", HRDATA, 32'd0);
    SI_Reset_N = 1'b1;
    #1 disp_chk("pre_first_edge");
    @(negedge SI_ClkIn);
    tick("first_edge");
    chk("first_en", {24'd0, IO_7SEGEN_N}, 32'h0000_00FE);
    chk("first_seg", {25'd0, IO_7SEG_N}, 32'h0000_0040);
    wr(2'd0, 32'h89AB_CDEF, 1'b0, 2'd0);
    repeat (36) tick("scan_hex");
    wr(2'd1, 32'hFFFF_FF0F, 1'b0, 2'd0);
    rd(2'd1);
    chk("digen_read", mread(2'd1), 32'h0000_000F);
    repeat (34) tick("scan_mask");
    wr(2'd1, 32'h0000_00FF, 1'b0, 2'd0);
    wr(2'd0, 32'h0000_1234, 1'b1, 2'd0);
    rd(2'd3);
    rd(2'd2);
    wr(2'd3, $urandom, 1'b0, 2'd0);
    wr(2'd2, $urandom, 1'b0, 2'd0);
    rd(2'd0);
    wr(2'd0, 32'h0000_0050, 1'b0, 2'd0);
    repeat (34) tick("scan_lz");
    for (int it = 0; it < 10; it++) begin
      d = $urandom;
      d = d >> (4 * $urandom_range(0, 7));
      wr(2'd0, d, 1'b0, 2'd0);
      if ($urandom_range(0, 1) == 1) wr(2'd1, $urandom, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
      k = $urandom_range(0, 2);
      HSEL = k != 0; HTRANS = k == 2 ? 2'b01 : k == 1 ? 2'b00 : 2'b10;
      HWRITE = 1'b1; HADDR = addr(2'($urandom_range(0, 1)));
      tick("ignored_addr");
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = $urandom;
      tick("ignored_data");
      chk("idle_hrdata", HRDATA, 32'd0);
      rd(2'($urandom_range(0, 3)));
      repeat ($urandom_range(4, 20)) tick("scan_rand");
    end
    for (int i = 0; i < 64 && !(n > 0 && ((n - 1) / DIV) % 8 == 5); i++) tick("seek_idx5");
    chk("reach_idx5", 32'(n > 0 && ((n - 1) / DIV) % 8 == 5), 32'd1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr(2'd0);
    tick("rst_wr_addr");
    HWDATA = 32'hDEAD_BEEF; HSEL = 1'b0; HTRANS = 2'b00;
    #2 SI_Reset_N = 1'b0;
    mdata = 32'd0; mdigen = 8'hFF;
    #1 disp_chk("async_reset");
    chk("async_reset_hrdata", HRDATA, 32'd0);
    repeat (3) tick("in_reset");
    SI_Reset_N = 1'b1;
    tick("restart");
    chk("restart_en", {24'd0, IO_7SEGEN_N}, 32'h0000_00FE);
    rd(2'd0);
    chk("lost_write", mread(2'd0), 32'd0);
    rd(2'd1);
    repeat (20) tick("scan_after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
